// File: rtl/cam_i2c_responder.sv
// I2C slave exposing a 16-bit register pointer over a small byte store; accepted write
// bytes are also streamed out as strobes, and reads are served from the store.
module cam_i2c_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h10,
    parameter int         MEM_AW     = 6
) (
    input  logic        clk400,
    input  logic        reset,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        wr_valid,
    output logic [15:0] wr_reg,
    output logic [7:0]  wr_data,
    output logic        busy
);
    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        REGH      = 4'd3,
        REGH_ACK  = 4'd4,
        REGL      = 4'd5,
        REGL_ACK  = 4'd6,
        WDATA     = 4'd7,
        WDATA_ACK = 4'd8,
        RDATA     = 4'd9,
        RDATA_ACK = 4'd10,
        IGNORE    = 4'd11
    } state_t;

    logic        scl_meta_r, scl_sync_r, scl_prev_r;
    logic        sda_meta_r, sda_sync_r, sda_prev_r;
    state_t      state_r, state_nxt_s;
    logic [3:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [6:0]  shift_r, shift_nxt_s;
    logic        ack_phase_r, ack_phase_nxt_s;
    logic        rw_r, rw_nxt_s;
    logic [7:0]  reg_hi_r, reg_hi_nxt_s;
    logic [15:0] ptr_r, ptr_nxt_s;
    logic        sda_oe_r, sda_oe_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        wr_valid_r, wr_valid_nxt_s;
    logic [15:0] wr_reg_r, wr_reg_nxt_s;
    logic [7:0]  wr_data_r, wr_data_nxt_s;
    logic        store_we_s;
    logic        scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0]  byte_s, rd_byte_s;

    // Store powers up cleared and is deliberately left out of reset.
    logic [7:0]  store_r [DEPTH] = '{default: 8'h00};

    assign scl_rise_s = scl_sync_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_sync_r & scl_prev_r;
    assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
    assign byte_s     = {shift_r, sda_sync_r};
    assign rd_byte_s  = store_r[ptr_r[MEM_AW-1:0]];

    // Two-flop synchronizers plus one history stage for edge detection.
    always_ff @(posedge clk400) begin
        if (reset) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_meta_r <= scl;
            scl_sync_r <= scl_meta_r;
            scl_prev_r <= scl_sync_r;
            sda_meta_r <= sda_in;
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    // Protocol state and output registers.
    always_ff @(posedge clk400) begin
        if (reset) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 7'd0;
            ack_phase_r <= 1'b0;
            rw_r        <= 1'b0;
            reg_hi_r    <= 8'd0;
            ptr_r       <= 16'd0;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            wr_valid_r  <= 1'b0;
            wr_reg_r    <= 16'd0;
            wr_data_r   <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            ack_phase_r <= ack_phase_nxt_s;
            rw_r        <= rw_nxt_s;
            reg_hi_r    <= reg_hi_nxt_s;
            ptr_r       <= ptr_nxt_s;
            sda_oe_r    <= sda_oe_nxt_s;
            busy_r      <= busy_nxt_s;
            wr_valid_r  <= wr_valid_nxt_s;
            wr_reg_r    <= wr_reg_nxt_s;
            wr_data_r   <= wr_data_nxt_s;
        end
    end

    // Byte store write port, fed by completed WDATA bytes.
    always_ff @(posedge clk400) begin
        if (store_we_s && !reset) begin
            store_r[ptr_r[MEM_AW-1:0]] <= byte_s;
        end else begin
            store_r[ptr_r[MEM_AW-1:0]] <= store_r[ptr_r[MEM_AW-1:0]];
        end
    end

    // Next-state logic; bus conditions override any bit sampled in the same cycle.
    always_comb begin
        state_nxt_s     = state_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shift_nxt_s     = shift_r;
        ack_phase_nxt_s = ack_phase_r;
        rw_nxt_s        = rw_r;
        reg_hi_nxt_s    = reg_hi_r;
        ptr_nxt_s       = ptr_r;
        sda_oe_nxt_s    = sda_oe_r;
        busy_nxt_s      = busy_r;
        wr_valid_nxt_s  = 1'b0;
        wr_reg_nxt_s    = wr_reg_r;
        wr_data_nxt_s   = wr_data_r;
        store_we_s      = 1'b0;
        if (stop_s) begin
            state_nxt_s     = IDLE;
            bit_cnt_nxt_s   = 4'd0;
            ack_phase_nxt_s = 1'b0;
            sda_oe_nxt_s    = 1'b0;
            busy_nxt_s      = 1'b0;
        end else if (start_s) begin
            state_nxt_s     = ADDR;
            bit_cnt_nxt_s   = 4'd0;
            ack_phase_nxt_s = 1'b0;
            sda_oe_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                ADDR, REGH, REGL, WDATA: begin
                    if (scl_rise_s) begin
                        shift_nxt_s = byte_s[6:0];
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_nxt_s   = 4'd0;
                            ack_phase_nxt_s = 1'b0;
                            case (state_r)
                                ADDR: begin
                                    if (byte_s[7:1] == SLAVE_ADDR) begin
                                        state_nxt_s = ADDR_ACK;
                                        rw_nxt_s    = byte_s[0];
                                        busy_nxt_s  = 1'b1;
                                    end else begin
                                        state_nxt_s = IGNORE;
                                        busy_nxt_s  = 1'b0;
                                    end
                                end
                                REGH: begin
                                    reg_hi_nxt_s = byte_s;
                                    state_nxt_s  = REGH_ACK;
                                end
                                REGL: begin
                                    ptr_nxt_s   = {reg_hi_r, byte_s};
                                    state_nxt_s = REGL_ACK;
                                end
                                WDATA: begin
                                    store_we_s     = 1'b1;
                                    wr_valid_nxt_s = 1'b1;
                                    wr_reg_nxt_s   = ptr_r;
                                    wr_data_nxt_s  = byte_s;
                                    ptr_nxt_s      = ptr_r + 16'd1;
                                    state_nxt_s    = WDATA_ACK;
                                end
                                default: state_nxt_s = IDLE;
                            endcase
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
                // First falling edge drives the ACK, the second releases it.
                ADDR_ACK, REGH_ACK, REGL_ACK, WDATA_ACK: begin
                    if (scl_fall_s) begin
                        if (!ack_phase_r) begin
                            sda_oe_nxt_s    = 1'b1;
                            ack_phase_nxt_s = 1'b1;
                        end else begin
                            sda_oe_nxt_s    = 1'b0;
                            ack_phase_nxt_s = 1'b0;
                            bit_cnt_nxt_s   = 4'd0;
                            case (state_r)
                                ADDR_ACK: begin
                                    if (rw_r) begin
                                        state_nxt_s  = RDATA;
                                        sda_oe_nxt_s = ~rd_byte_s[7];
                                    end else begin
                                        state_nxt_s = REGH;
                                    end
                                end
                                REGH_ACK:            state_nxt_s = REGL;
                                REGL_ACK, WDATA_ACK: state_nxt_s = WDATA;
                                default:             state_nxt_s = IDLE;
                            endcase
                        end
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                // bit_cnt counts bits already clocked out; 8 means hand the line back.
                RDATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_oe_nxt_s  = 1'b0;
                            bit_cnt_nxt_s = 4'd0;
                            state_nxt_s   = RDATA_ACK;
                        end else begin
                            sda_oe_nxt_s = ~rd_byte_s[3'd7 - bit_cnt_r[2:0]];
                        end
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                RDATA_ACK: begin
                    sda_oe_nxt_s = 1'b0;
                    if (scl_rise_s) begin
                        ptr_nxt_s     = ptr_r + 16'd1;
                        bit_cnt_nxt_s = 4'd0;
                        if (sda_sync_r) begin
                            state_nxt_s = IGNORE;
                            busy_nxt_s  = 1'b0;
                        end else begin
                            state_nxt_s = RDATA;
                        end
                    end else begin
                        state_nxt_s = RDATA_ACK;
                    end
                end
                IGNORE: begin
                    sda_oe_nxt_s = 1'b0;
                    busy_nxt_s   = 1'b0;
                end
                IDLE: begin
                    sda_oe_nxt_s = 1'b0;
                end
                default: begin
                    state_nxt_s  = IDLE;
                    sda_oe_nxt_s = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_r;
    assign wr_valid = wr_valid_r;
    assign wr_reg   = wr_reg_r;
    assign wr_data  = wr_data_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_cam_i2c_responder.sv
// Bench for cam_i2c_responder: a bit-banged I2C master plus a byte-array/pointer model
// of the register store, with directed scenarios followed by randomized transactions.
module tb_cam_i2c_responder;
    localparam logic [6:0] SA = 7'h10;
    localparam int         Q  = 4;

    logic        clk400 = 1'b0;
    logic        reset  = 1'b1;
    logic        scl    = 1'b1;
    logic        sda_m  = 1'b1;
    logic        sda_in;
    logic        sda_oe, wr_valid, busy;
    logic [15:0] wr_reg;
    logic [7:0]  wr_data;

    // Open-drain bus: the line is low if either side pulls it.
    assign sda_in = sda_m & ~sda_oe;

    always #5 clk400 = ~clk400;

    cam_i2c_responder #(.SLAVE_ADDR(SA), .MEM_AW(6)) dut (
        .clk400(clk400), .reset(reset), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
        .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data), .busy(busy)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  m_mem [64];
    logic [15:0] m_ptr;
    logic [23:0] exp_q [$];
    logic [7:0]  wbuf [8];
    logic [23:0] got_arr [1024];
    int          got_n = 0;
    int          got_rd = 0;
    int          oe_cnt = 0;
    int          busy_cnt = 0;

    // Record every strobe and count cycles with sda_oe / busy high.
    always @(negedge clk400) begin
        if (wr_valid === 1'b1) begin
            got_arr[got_n] <= {wr_reg, wr_data};
            got_n <= got_n + 1;
        end
        if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk400);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wait_q();
            scl = 1'b1;   wait_q(); wait_q();
            scl = 1'b0;   wait_q();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ak);
        send_bits(b, 8);
        sda_m = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        ak = (sda_in === 1'b0);
        wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic read_byte(output logic [7:0] b, input bit nack, input string tag);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_q();
            scl = 1'b1;   wait_q();
            b[i] = sda_in;
            wait_q();
            scl = 1'b0;   wait_q();
        end
        sda_m = nack; wait_q();
        scl = 1'b1;   wait_q();
        chk({tag, " master-ack oe"}, 32'(sda_oe), 32'd0);
        wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic chk_strobes(input string tag);
        int got;
        repeat (4) @(negedge clk400);
        got = got_n - got_rd;
        chk({tag, " strobe count"}, 32'(got), 32'(exp_q.size()));
        for (int i = 0; i < got && i < exp_q.size(); i++)
            chk({tag, " strobe"}, 32'(got_arr[got_rd + i]), 32'(exp_q[i]));
        got_rd = got_n;
        exp_q.delete();
    endtask

    // Full write transaction; the model applies it only if the address is ours.
    task automatic txn_write(input logic [6:0] a, input logic [15:0] r, input int n, input string tag);
        bit ak;
        bit hit;
        hit = (a == SA);
        i2c_start();
        send_byte({a, 1'b0}, ak); chk({tag, " addr ack"}, 32'(ak), 32'(hit));
        chk({tag, " busy"}, 32'(busy), 32'(hit));
        send_byte(r[15:8], ak);   chk({tag, " regh ack"}, 32'(ak), 32'(hit));
        send_byte(r[7:0], ak);    chk({tag, " regl ack"}, 32'(ak), 32'(hit));
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ak); chk({tag, " data ack"}, 32'(ak), 32'(hit));
        end
        i2c_stop();
        if (hit) begin
            m_ptr = r;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({m_ptr, wbuf[i]});
                m_mem[m_ptr[5:0]] = wbuf[i];
                m_ptr = m_ptr + 16'd1;
            end
        end
        chk_strobes(tag);
    endtask

    // Read of n bytes, optionally preceded by a pointer write and repeated START.
    task automatic txn_read(input bit set_ptr, input logic [15:0] r, input int n, input string tag);
        bit ak;
        logic [7:0] b;
        i2c_start();
        if (set_ptr) begin
            send_byte({SA, 1'b0}, ak); chk({tag, " waddr ack"}, 32'(ak), 32'd1);
            send_byte(r[15:8], ak);    chk({tag, " regh ack"}, 32'(ak), 32'd1);
            send_byte(r[7:0], ak);     chk({tag, " regl ack"}, 32'(ak), 32'd1);
            m_ptr = r;
            i2c_start();
        end
        send_byte({SA, 1'b1}, ak); chk({tag, " raddr ack"}, 32'(ak), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(b, (i == n - 1), tag);
            chk({tag, " rdata"}, 32'(b), 32'(m_mem[m_ptr[5:0]]));
            m_ptr = m_ptr + 16'd1;
        end
        i2c_stop();
        chk_strobes(tag);
    endtask

    initial begin
        bit ak;
        int snap_oe, snap_busy, op, n;
        logic [6:0] a;
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
        m_ptr = 16'h0000;

        repeat (5) @(negedge clk400);
        reset = 1'b0;
        repeat (3) @(negedge clk400);
        chk("reset sda_oe",   32'(sda_oe),   32'd0);
        chk("reset wr_valid", 32'(wr_valid), 32'd0);
        chk("reset wr_reg",   32'(wr_reg),   32'd0);
        chk("reset wr_data",  32'(wr_data),  32'd0);
        chk("reset busy",     32'(busy),     32'd0);

        wbuf[0] = 8'h01;
        txn_write(SA, 16'h0100, 1, "w_single");
        chk("idle busy", 32'(busy), 32'd0);

        snap_oe = oe_cnt; snap_busy = busy_cnt;
        wbuf[0] = 8'h55;
        txn_write(7'h11, 16'h0100, 1, "w_foreign");
        chk("foreign oe cycles",   32'(oe_cnt - snap_oe),     32'd0);
        chk("foreign busy cycles", 32'(busy_cnt - snap_busy), 32'd0);

        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        txn_write(SA, 16'h0003, 2, "w_prefill");
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
        txn_write(SA, 16'h3000, 3, "w_burst");
        txn_read(1'b1, 16'h3001, 2, "r_burst");
        txn_read(1'b0, 16'h0000, 1, "r_ptr3003");

        // STOP after only the high register byte must not disturb the pointer.
        i2c_start();
        send_byte({SA, 1'b0}, ak); chk("p_regh addr ack", 32'(ak), 32'd1);
        send_byte(8'h12, ak);      chk("p_regh regh ack", 32'(ak), 32'd1);
        i2c_stop();
        chk_strobes("p_regh");
        txn_read(1'b0, 16'h0000, 1, "r_after_p_regh");

        // A half data byte is dropped: no strobe, no store write.
        i2c_start();
        send_byte({SA, 1'b0}, ak); chk("p_data addr ack", 32'(ak), 32'd1);
        send_byte(8'h00, ak);      chk("p_data regh ack", 32'(ak), 32'd1);
        send_byte(8'h05, ak);      chk("p_data regl ack", 32'(ak), 32'd1);
        send_bits(8'h77, 4);
        i2c_stop();
        m_ptr = 16'h0005;
        chk_strobes("p_data");
        txn_read(1'b0, 16'h0000, 1, "r_after_p_data");

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        txn_write(SA, 16'hFFFF, 2, "w_wrap");

        // Reset while the address ACK is being driven.
        i2c_start();
        send_bits({SA, 1'b0}, 8);
        sda_m = 1'b1; wait_q();
        chk("mid-ack oe driven", 32'(sda_oe), 32'd1);
        reset = 1'b1; @(negedge clk400);
        reset = 1'b0;
        chk("mid-ack reset oe",      32'(sda_oe),  32'd0);
        chk("mid-ack reset busy",    32'(busy),    32'd0);
        chk("mid-ack reset wr_reg",  32'(wr_reg),  32'd0);
        chk("mid-ack reset wr_data", 32'(wr_data), 32'd0);
        m_ptr = 16'h0000;
        scl = 1'b1; wait_q();
        chk("post-reset ignore oe", 32'(sda_oe), 32'd0);
        wait_q();
        scl = 1'b0; wait_q();
        wbuf[0] = 8'h01;
        txn_write(SA, 16'h0100, 1, "w_after_reset");

        for (int k = 0; k < 12; k++) begin
            op = int'($urandom_range(0, 3));
            n  = int'($urandom_range(1, 3));
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            if (op == 0) begin
                a = 7'($urandom);
                if (a == SA) a = a ^ 7'h01;
                txn_write(a, 16'($urandom), n, "rnd_foreign");
            end else if (op == 1) begin
                txn_write(SA, 16'($urandom), n, "rnd_write");
            end else if (op == 2) begin
                txn_read(1'b1, 16'($urandom), n, "rnd_read_set");
            end else begin
                txn_read(1'b0, 16'h0000, n, "rnd_read_cur");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
